// File: rtl/viterbi_acs_array_if.sv
// viterbi_acs_array_if: symbol-in / decision-out bus of the Viterbi ACS array
interface viterbi_acs_array_if #(
  parameter int K        = 7,
  parameter int NUM_POLY = 6,
  parameter int SOFT_W   = 4,
  parameter int PM_W     = 16
);
  logic                         start_i;
  logic                         tail_biting_en_i;
  logic [15:0]                  frame_len_i;
  logic [2:0]                   num_poly_i;
  logic [NUM_POLY*8-1:0]        poly_i;
  logic [NUM_POLY*SOFT_W-1:0]   soft_i;
  logic                         sym_valid_i;
  logic                         sym_ready_o;
  logic                         dec_valid_o;
  logic                         dec_ready_i;
  logic [(1<<(K-1))-1:0]        survivor_o;
  logic [K-2:0]                 best_state_o;
  logic [PM_W-1:0]              step_min_o;
  logic                         dec_last_o;
  logic                         busy_o;
  logic                         done_o;
  modport master (
    output start_i, tail_biting_en_i, frame_len_i, num_poly_i, poly_i, soft_i, sym_valid_i, dec_ready_i,
    input  sym_ready_o, dec_valid_o, survivor_o, best_state_o, step_min_o, dec_last_o, busy_o, done_o
  );
  modport slave (
    input  start_i, tail_biting_en_i, frame_len_i, num_poly_i, poly_i, soft_i, sym_valid_i, dec_ready_i,
    output sym_ready_o, dec_valid_o, survivor_o, best_state_o, step_min_o, dec_last_o, busy_o, done_o
  );
endinterface

// File: rtl/viterbi_acs_array.sv
// viterbi_acs_array: one trellis step per soft symbol with normalised path metrics and survivor output
module viterbi_acs_array #(
  parameter int K        = 7,
  parameter int NUM_POLY = 6,
  parameter int SOFT_W   = 4,
  parameter int PM_W     = 16
) (
  input logic clk_i,
  input logic rst_an_i,
  input logic rst_sync_i,
  viterbi_acs_array_if.slave bus
);
  localparam int S    = 1 << (K - 1);
  localparam int M    = (1 << (SOFT_W - 1)) - 1;
  localparam int BM_W = SOFT_W + $clog2(NUM_POLY);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(1) << (PM_W - 2);
  logic [1:0]        state_q;
  logic [15:0]       cnt_q;
  logic [PM_W-1:0]   pm_q [S];
  logic              dec_valid_q;
  logic              last_q;
  logic [S-1:0]      surv_q;
  logic [K-2:0]      best_q;
  logic [PM_W-1:0]   min_q;
  logic [2:0]        np;
  logic [SOFT_W-1:0] lc0 [NUM_POLY];
  logic [BM_W-1:0]   bm [2*S];
  logic [PM_W:0]     cand0 [S];
  logic [PM_W:0]     cand1 [S];
  logic [PM_W-1:0]   sat0 [S];
  logic [PM_W-1:0]   sat1 [S];
  logic [PM_W-1:0]   new_pm [S];
  logic [PM_W-1:0]   pm_d [S];
  logic [S-1:0]      surv_d;
  logic [K-2:0]      best_d;
  logic [PM_W-1:0]   min_d;
  logic              sym_ready;
  logic              sym_acc;
  logic              dec_acc;
  // Clamp the lane count; per-lane cost for code bit 0 is M + soft (with -(M+1) clamped to -M), for bit 1 it is 2M minus that.
  always_comb begin
    np = bus.num_poly_i < 3'd2 ? 3'd2 : (bus.num_poly_i > 3'(NUM_POLY) ? 3'(NUM_POLY) : bus.num_poly_i);
    for (int n = 0; n < NUM_POLY; n++)
      lc0[n] = bus.soft_i[n*SOFT_W +: SOFT_W] == {1'b1, {(SOFT_W-1){1'b0}}} ? '0 : bus.soft_i[n*SOFT_W +: SOFT_W] + SOFT_W'(M);
  end
  // Branch metric for every encoder register value r = {u, s}.
  always_comb begin
    for (int r = 0; r < 2*S; r++) begin
      bm[r] = '0;
      for (int n = 0; n < NUM_POLY; n++)
        if (3'(n) < np) bm[r] = bm[r] + BM_W'(^(K'(r) & bus.poly_i[n*8 +: K]) ? SOFT_W'(2*M) - lc0[n] : lc0[n]);
    end
  end
  // Add-compare-select per new state, then minimum search and normalisation.
  always_comb begin
    for (int j = 0; j < S; j++) begin
      cand0[j]  = {1'b0, pm_q[(2*j) % S]} + (PM_W+1)'(bm[(j / (S/2)) * S + (2*j) % S]);
      cand1[j]  = {1'b0, pm_q[(2*j) % S + 1]} + (PM_W+1)'(bm[(j / (S/2)) * S + (2*j) % S + 1]);
      sat0[j]   = cand0[j][PM_W] ? '1 : cand0[j][PM_W-1:0];
      sat1[j]   = cand1[j][PM_W] ? '1 : cand1[j][PM_W-1:0];
      surv_d[j] = sat1[j] < sat0[j];
      new_pm[j] = surv_d[j] ? sat1[j] : sat0[j];
    end
    min_d  = new_pm[0];
    best_d = '0;
    for (int j = 1; j < S; j++)
      if (new_pm[j] < min_d) begin
        min_d  = new_pm[j];
        best_d = (K-1)'(j);
      end
    for (int j = 0; j < S; j++) pm_d[j] = new_pm[j] - min_d;
  end
  assign sym_ready        = state_q == RUN && (!dec_valid_q || bus.dec_ready_i);
  assign sym_acc          = sym_ready && bus.sym_valid_i && !bus.start_i && !rst_sync_i;
  assign dec_acc          = dec_valid_q && bus.dec_ready_i;
  assign bus.sym_ready_o  = sym_ready;
  assign bus.dec_valid_o  = dec_valid_q;
  assign bus.survivor_o   = surv_q;
  assign bus.best_state_o = best_q;
  assign bus.step_min_o   = min_q;
  assign bus.dec_last_o   = last_q;
  assign bus.busy_o       = state_q != IDLE;
  assign bus.done_o       = state_q == DRAIN && dec_acc && !bus.start_i && !rst_sync_i;
  // Frame control, path-metric update and decision output registers.
  always_ff @(posedge clk_i or negedge rst_an_i)
    if (!rst_an_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pm_q        <= '{default: '0};
      dec_valid_q <= 1'b0;
      last_q      <= 1'b0;
      surv_q      <= '0;
      best_q      <= '0;
      min_q       <= '0;
    end else if (rst_sync_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pm_q        <= '{default: '0};
      dec_valid_q <= 1'b0;
      last_q      <= 1'b0;
      surv_q      <= '0;
      best_q      <= '0;
      min_q       <= '0;
    end else if (bus.start_i && (state_q != IDLE || bus.frame_len_i != '0)) begin
      state_q     <= bus.frame_len_i != '0 ? RUN : IDLE;
      cnt_q       <= bus.frame_len_i;
      dec_valid_q <= 1'b0;
      last_q      <= 1'b0;
      for (int j = 0; j < S; j++) pm_q[j] <= bus.tail_biting_en_i || j == 0 ? '0 : PM_INIT;
    end else if (sym_acc) begin
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      best_q      <= best_d;
      min_q       <= min_d;
      dec_valid_q <= 1'b1;
      last_q      <= cnt_q == 16'd1;
      cnt_q       <= cnt_q - 16'd1;
      if (cnt_q == 16'd1) state_q <= DRAIN;
    end else if (dec_acc) begin
      dec_valid_q <= 1'b0;
      if (state_q == DRAIN) state_q <= IDLE;
    end
endmodule

// File: tb/tb_viterbi_acs_array.sv
// tb_viterbi_acs_array: scoreboard bench for the ACS array against a forward-trellis reference model
module tb_viterbi_acs_array;
  localparam int K    = 3;
  localparam int NP   = 2;
  localparam int SW   = 4;
  localparam int PW   = 16;
  localparam int S    = 1 << (K - 1);
  localparam int MX   = (1 << (SW - 1)) - 1;
  localparam int PMAX = (1 << PW) - 1;
  typedef struct packed {
    logic [S-1:0]  surv;
    logic [K-2:0]  best;
    logic [PW-1:0] mn;
    logic          last;
  } item_t;
  logic clk = 0;
  logic rst_an;
  logic rst_sync;
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   dones = 0;
  int   rdy_mode = 2;
  item_t q[$];
  int   pm [S];
  int   cur_len;
  int   cur_step;
  logic [7:0] cur_poly [NP];
  logic [2:0] cur_np;
  item_t it_m;
  logic  hs_m;
  logic  exp_done_m;
  viterbi_acs_array_if #(.K(K), .NUM_POLY(NP), .SOFT_W(SW), .PM_W(PW)) bus ();
  viterbi_acs_array #(.K(K), .NUM_POLY(NP), .SOFT_W(SW), .PM_W(PW)) dut (
    .clk_i(clk), .rst_an_i(rst_an), .rst_sync_i(rst_sync), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic set_cfg(input logic [2:0] np_v, input logic [7:0] p0, input logic [7:0] p1);
    cur_np = np_v;
    cur_poly[0] = p0;
    cur_poly[1] = p1;
    bus.num_poly_i = np_v;
    bus.poly_i = {p1, p0};
  endtask
  task automatic model_step(input logic [NP*SW-1:0] sv, output item_t it);
    int newpm [S];
    int npc, r, ns, bm, s, c, cand, mn, best;
    logic signed [SW-1:0] x;
    logic [S-1:0] surv;
    npc = int'(cur_np);
    if (npc < 2) npc = 2;
    if (npc > NP) npc = NP;
    surv = '0;
    for (int i = 0; i < S; i++) newpm[i] = 1 << 30;
    for (int p = 0; p < S; p++)
      for (int u = 0; u < 2; u++) begin
        r = (u << (K - 1)) | p;
        ns = r >> 1;
        bm = 0;
        for (int n = 0; n < npc; n++) begin
          x = sv[n*SW +: SW];
          s = x;
          if (s < -MX) s = -MX;
          c = $countones(r & int'(cur_poly[n]) & ((1 << K) - 1)) % 2;
          bm += (c == 1) ? MX - s : MX + s;
        end
        cand = pm[p] + bm;
        if (cand > PMAX) cand = PMAX;
        if (cand < newpm[ns]) begin
          newpm[ns] = cand;
          surv[ns] = (p % 2) == 1;
        end
      end
    mn = newpm[0];
    best = 0;
    for (int i = 1; i < S; i++)
      if (newpm[i] < mn) begin
        mn = newpm[i];
        best = i;
      end
    for (int i = 0; i < S; i++) pm[i] = newpm[i] - mn;
    cur_step++;
    it.surv = surv;
    it.best = (K-1)'(best);
    it.mn = PW'(mn);
    it.last = cur_step == cur_len;
  endtask
  task automatic start_frame(input logic tb_en, input int len);
    bus.sym_valid_i = 0;
    bus.start_i = 1;
    bus.tail_biting_en_i = tb_en;
    bus.frame_len_i = 16'(len);
    q.delete();
    for (int i = 0; i < S; i++) pm[i] = (tb_en || i == 0) ? 0 : 1 << (PW - 2);
    cur_len = len;
    cur_step = 0;
    @(posedge clk); #1;
    bus.start_i = 0;
    @(negedge clk);
    chk("start_busy", bus.busy_o, len != 0);
    chk("start_ready", bus.sym_ready_o, len != 0);
    chk("start_dec_valid", bus.dec_valid_o, 0);
    @(posedge clk); #1;
  endtask
  task automatic send_sym(input logic [NP*SW-1:0] sv, input bit dir, input int dbest, input int dmin);
    item_t it;
    logic acc;
    acc = 0;
    bus.soft_i = sv;
    bus.sym_valid_i = 1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = bus.sym_ready_o;
      if (acc) begin
        model_step(sv, it);
        if (dir) begin
          it.best = (K-1)'(dbest);
          it.mn = PW'(dmin);
        end
        q.push_back(it);
      end
      @(posedge clk); #1;
    end
    bus.sym_valid_i = 0;
    chk("sym_accept", acc, 1);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy_o || q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 500, 1);
    @(posedge clk); #1;
  endtask
  // Decision-side driver: random or forced ready, updated just after each edge.
  initial forever begin
    @(posedge clk); #2;
    bus.dec_ready_i = rdy_mode == 0 ? ($urandom_range(0, 3) != 0) : (rdy_mode == 2);
  end
  // Monitor: every accepted decision is checked against the oldest expected step.
  initial forever begin
    @(negedge clk);
    hs_m = rst_an && bus.dec_valid_o && bus.dec_ready_i;
    exp_done_m = 0;
    if (hs_m) begin
      chk("dec_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        it_m = q.pop_front();
        chk("survivor", bus.survivor_o, it_m.surv);
        chk("best_state", bus.best_state_o, it_m.best);
        chk("step_min", bus.step_min_o, it_m.mn);
        chk("dec_last", bus.dec_last_o, it_m.last);
        pops++;
        exp_done_m = it_m.last && !bus.start_i && !rst_sync;
      end
    end
    if (hs_m || bus.done_o) chk("done", bus.done_o, exp_done_m);
    if (bus.done_o) dones++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int p0, d0;
    int len;
    rst_an = 0;
    rst_sync = 0;
    bus.start_i = 0;
    bus.tail_biting_en_i = 0;
    bus.frame_len_i = 0;
    bus.num_poly_i = 2;
    bus.poly_i = 0;
    bus.soft_i = 0;
    bus.sym_valid_i = 0;
    repeat (4) begin
      @(posedge clk); #1;
      bus.start_i = 1'($urandom);
      bus.tail_biting_en_i = 1'($urandom);
      bus.frame_len_i = 16'($urandom);
      bus.num_poly_i = 3'($urandom);
      bus.poly_i = 16'($urandom);
      bus.soft_i = 8'($urandom);
      bus.sym_valid_i = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_sym_ready", bus.sym_ready_o, 0);
    chk("rst_dec_valid", bus.dec_valid_o, 0);
    chk("rst_survivor", bus.survivor_o, 0);
    chk("rst_best", bus.best_state_o, 0);
    chk("rst_step_min", bus.step_min_o, 0);
    chk("rst_last", bus.dec_last_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    @(posedge clk); #1;
    bus.start_i = 0;
    bus.sym_valid_i = 0;
    rst_an = 1;
    repeat (3) begin
      @(posedge clk); #1;
      bus.sym_valid_i = 1'($urandom);
      @(negedge clk);
      chk("idle_no_ready", bus.sym_ready_o, 0);
    end
    @(posedge clk); #1;
    bus.sym_valid_i = 0;
    // zero-length start in IDLE is ignored
    set_cfg(3'd2, 8'h07, 8'h05);
    start_frame(0, 0);
    // noise-free zero-start frame: inputs 1,0,1,1
    d0 = dones;
    p0 = pops;
    rdy_mode = 2;
    start_frame(0, 4);
    send_sym(8'h77, 1, 2, 0);
    send_sym(8'h97, 1, 1, 0);
    send_sym(8'h99, 1, 2, 0);
    send_sym(8'h79, 1, 3, 0);
    wait_idle();
    chk("nf_steps", pops - p0, 4);
    chk("nf_done_count", dones - d0, 1);
    // tail-biting with erasures
    start_frame(1, 1);
    send_sym(8'h00, 1, 0, 14);
    wait_idle();
    // clamp: -8 behaves like -7
    start_frame(0, 1);
    send_sym(8'h88, 1, 0, 0);
    wait_idle();
    start_frame(0, 1);
    send_sym(8'h99, 1, 0, 0);
    wait_idle();
    // backpressure mid-frame
    p0 = pops;
    start_frame(0, 8);
    repeat (3) send_sym(8'($urandom), 0, 0, 0);
    rdy_mode = 1;
    bus.soft_i = 8'($urandom);
    bus.sym_valid_i = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_no_ready", bus.sym_ready_o, 0);
      chk("bp_valid_held", bus.dec_valid_o, 1);
      chk("bp_surv_frozen", bus.survivor_o, q[0].surv);
      chk("bp_min_frozen", bus.step_min_o, q[0].mn);
      @(posedge clk); #1;
    end
    rdy_mode = 2;
    send_sym(bus.soft_i, 0, 0, 0);
    repeat (4) send_sym(8'($urandom), 0, 0, 0);
    wait_idle();
    chk("bp_steps", pops - p0, 8);
    // abort after step 2 of 4, then a full new frame
    d0 = dones;
    start_frame(0, 4);
    repeat (2) send_sym(8'($urandom), 0, 0, 0);
    rdy_mode = 1;
    start_frame(0, 4);
    p0 = pops;
    rdy_mode = 0;
    repeat (4) send_sym(8'($urandom), 0, 0, 0);
    wait_idle();
    chk("abort_steps", pops - p0, 4);
    chk("abort_done_count", dones - d0, 1);
    // synchronous clear mid-frame
    rdy_mode = 2;
    start_frame(1, 6);
    repeat (2) send_sym(8'($urandom), 0, 0, 0);
    rst_sync = 1;
    @(posedge clk); #1;
    rst_sync = 0;
    q.delete();
    @(negedge clk);
    chk("sclr_busy", bus.busy_o, 0);
    chk("sclr_dec_valid", bus.dec_valid_o, 0);
    chk("sclr_ready", bus.sym_ready_o, 0);
    chk("sclr_step_min", bus.step_min_o, 0);
    chk("sclr_survivor", bus.survivor_o, 0);
    @(posedge clk); #1;
    // random frames with random codes, lane counts and flow control
    repeat (8) begin
      set_cfg(3'($urandom), 8'($urandom), 8'($urandom));
      len = $urandom_range(1, 10);
      rdy_mode = 0;
      d0 = dones;
      p0 = pops;
      start_frame(1'($urandom), len);
      repeat (len) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_sym(8'($urandom), 0, 0, 0);
      end
      wait_idle();
      chk("rand_steps", pops - p0, len);
      chk("rand_done_count", dones - d0, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/viterbi_acs_array.md
# viterbi_acs_array

Parametrised add-compare-select array for a rate-1/N convolutional Viterbi decoder with constraint length K, one trellis step per accepted soft symbol. Computes branch metrics internally from the packed soft inputs and the generator polynomials. Updates 2^(K-1) normalised path metrics and emits one survivor-decision word per step, plus the best state, to the traceback unit downstream. Supports zero-start and tail-biting initialisation, frame-length tracking and valid/ready flow control on both sides.

## Interface
- K, 7: constraint length, 3..7; S = 2^(K-1) states.
- NUM_POLY, 6: maximum polynomials (lanes), 2..6.
- SOFT_W, 4: signed soft-bit width.
- PM_W, 16: path-metric width, unsigned.
- clk_i  in  1  clock
- rst_an_i  in  1  reset, asynchronous, active-low.
- rst_sync_i  in  1  synchronous clear; same effect as reset.
- start_i  in  1  pulse: initialise and begin a frame.
- tail_biting_en_i  in  1  sampled at start_i; 1 = all PMs start at 0.
- frame_len_i  in  16  symbols per frame, sampled at start_i.
- num_poly_i  in  3  active lanes; clamped to 2..NUM_POLY.
- poly_i  in  NUM_POLY*8  lane n at [n*8 +: 8]; only bits [K-1:0] are used.
- soft_i  in  NUM_POLY*SOFT_W  lane n at [n*SOFT_W +: SOFT_W]; positive means '1'.
- sym_valid_i / sym_ready_o  in/out  1  symbol handshake.
- dec_valid_o / dec_ready_i  out/in  1  decision handshake.
- survivor_o  out  S  decision bit per new state.
- best_state_o  out  K-1  argmin of the new PMs; ties go to the lowest index.
- step_min_o  out  PM_W  minimum of the new PMs before normalisation.
- dec_last_o  out  1  marks the final step of the frame.
- busy_o  out  1  FSM not IDLE.
- done_o  out  1  one-cycle pulse when the last decision is accepted.

## Operation
- Trellis convention: state s[K-2:0]; input u; register r = {u, s}; next state s' = {u, s[K-2:1]}.
  - Predecessors of s' are p0 = {s'[K-3:0], 0} and p1 = p0 | 1.
  - Code bit c_n = XOR-reduce(r & poly_n[K-1:0]).
- Branch metric:
  - Each soft value is clamped to ±M, where M = 2^(SOFT_W-1)-1.
  - Lane cost = M - soft if c_n = 1, else M + soft.
  - bm = sum of lane costs over lanes 0..num_poly_i-1.
- ACS:
  - cand_j = PM[p_j] + bm_j, saturating at 2^PM_W-1.
  - new = min(cand_0, cand_1); survivor bit = 1 only if cand_1 < cand_0 (a tie picks p0).
- Normalisation: step_min = min over all new values. Stored PM = new - step_min, so the stored minimum is always 0.
- Initialisation at start_i:
  - tail_biting_en_i = 1: all PMs = 0.
  - tail_biting_en_i = 0: PM[0] = 0, all others = 2^(PM_W-2).
- FSM:
  - IDLE -> RUN on start_i with frame_len_i != 0. A frame length of 0 is ignored.
  - RUN -> DRAIN when symbol number frame_len is accepted.
  - DRAIN -> IDLE when the last decision is accepted; done_o pulses in that cycle.
- start_i in RUN or DRAIN aborts the frame and restarts:
  - PMs are re-initialised and the counter reloaded.
  - dec_valid_o clears; no done_o is issued.
  - The FSM enters RUN, or IDLE if frame_len_i = 0.
- rst_sync_i takes priority over start_i.

## Timing
- Reset / rst_sync_i: all PMs = 0, FSM IDLE, and every output = 0 (sym_ready_o, dec_valid_o, survivor_o, best_state_o, step_min_o, dec_last_o, busy_o, done_o).
- sym_ready_o = (FSM == RUN) && (!dec_valid_o || dec_ready_i).
- On an accepted symbol, the PMs and output registers update at the same edge. dec_valid_o is 1 the following cycle (latency 1).
- dec_valid_o holds, with outputs stable, until dec_ready_i. Back-to-back acceptance gives 1 step per cycle.
- start_i at edge t gives sym_ready_o = 1 at t+1. Symbols presented together with start_i are not accepted.
- dec_last_o is valid with dec_valid_o on step frame_len.

## Test plan
- Reset: hold rst_an_i low with random inputs -> all outputs 0; after release, sym_ready_o stays 0 until start_i.
- Zero-start, noise-free (K=3, NUM_POLY=2, polys 3'b111/3'b101, frame_len 4, inputs 1,0,1,1):
  - Stimulus: soft ±7 for codewords 11, 10, 00, 01.
  - Response: best_state 2, 1, 2, 3; step_min 0 each step; survivor_o[2] = 0 on step 1; dec_last_o on step 4; done_o one pulse on its acceptance.
- Tail-biting (same config), soft all 0 -> step 1 gives step_min 14, best_state 0, survivor_o = 0.
- Backpressure: dec_ready_i low for 5 cycles mid-frame -> sym_ready_o = 0 and outputs frozen; no step lost or duplicated after release.
- Clamp: soft -8 on both lanes from state 0 (zero-start), input 0 -> step_min 0, best_state 0; identical results to soft -7.
- Abort: start_i after step 2 of 4 -> dec_valid_o = 0 next cycle, no done_o, PMs re-initialised; the new frame delivers 4 steps.
